// File: rtl/sensor_reg_pkg.sv
// ---------------------------------------------------------------------------
// sensor_reg_pkg
// Shared constants for the sensor register bank: register addresses,
// CTRL/STATUS bit positions and the default WHO_AM_I value.
// ---------------------------------------------------------------------------
package sensor_reg_pkg;

    // Register map
    localparam logic [7:0] ADDR_WHO_AM_I = 8'h00;
    localparam logic [7:0] ADDR_CTRL     = 8'h01;
    localparam logic [7:0] ADDR_STATUS   = 8'h02;
    localparam logic [7:0] ADDR_FIFO_CNT = 8'h03;
    localparam logic [7:0] ADDR_FIFO_DATA = 8'h04;
    localparam logic [7:0] ADDR_WATERMARK = 8'h05;

    // CTRL bit positions
    localparam int CTRL_EN      = 0;
    localparam int CTRL_FLUSH   = 1;
    localparam int CTRL_WM_IEN  = 2;
    localparam int CTRL_OVF_IEN = 3;

    // STATUS bit positions
    localparam int STAT_EMPTY = 0;
    localparam int STAT_FULL  = 1;
    localparam int STAT_OVF   = 2;
    localparam int STAT_UDF   = 3;
    localparam int STAT_WM    = 4;

    localparam logic [7:0] DEVICE_ID_DEFAULT = 8'hA5;

endpackage

// File: rtl/sensor_reg_bank_if.sv
// ---------------------------------------------------------------------------
// sensor_reg_bank_if
// Register-access bus between the I2C slave (master modport) and the
// register bank (slave modport).
//   reg_addr   : register address
//   wr_data    : write data
//   write_en   : single-cycle write strobe
//   fifo_rd_en : single-cycle FIFO pop strobe (acts only at FIFO_DATA)
//   rd_data    : combinational read data back to the I2C slave
// ---------------------------------------------------------------------------
interface sensor_reg_bank_if;
    logic [7:0] reg_addr;
    logic [7:0] wr_data;
    logic       write_en;
    logic       fifo_rd_en;
    logic [7:0] rd_data;

    modport master (output reg_addr, output wr_data, output write_en,
                    output fifo_rd_en, input rd_data);
    modport slave  (input reg_addr, input wr_data, input write_en,
                    input fifo_rd_en, output rd_data);
endinterface

// File: rtl/sensor_sample_fifo.sv
// ---------------------------------------------------------------------------
// sensor_sample_fifo
// Synchronous show-ahead FIFO for 8-bit sensor samples.
//   clk, rst    : clock, synchronous active-high reset (pointers/count only)
//   wrEn/wrData : push request; accepted when not full, or when full and a
//                 valid pop happens in the same cycle
//   rdEn        : pop request; accepted only when not empty
//   flush       : clears pointers and count, overriding push/pop
//   headData    : entry at the read pointer (show-ahead)
//   count       : occupancy 0..DEPTH; empty/full flags
// ---------------------------------------------------------------------------
module sensor_sample_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wrEn,
    input  logic [7:0]    wrData,
    input  logic          rdEn,
    input  logic          flush,
    output logic [7:0]    headData,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full
);

    localparam logic [AW:0] FULL_COUNT = DEPTH[AW:0];

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wrPtr_r;
    logic [AW-1:0] rdPtr_r;
    logic [AW:0]   count_r;
    logic          popOk_s;
    logic          pushOk_s;

    assign empty    = (count_r == {(AW+1){1'b0}});
    assign full     = (count_r == FULL_COUNT);
    assign popOk_s  = rdEn & ~empty;
    // A push into a full FIFO still lands when a pop frees the head slot.
    assign pushOk_s = wrEn & (~full | popOk_s);
    assign count    = count_r;
    assign headData = mem[rdPtr_r];

    // Pointer and occupancy tracking; flush wins over any push/pop.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wrPtr_r <= {AW{1'b0}};
            rdPtr_r <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else begin
            if (pushOk_s) wrPtr_r <= wrPtr_r + {{(AW-1){1'b0}}, 1'b1};
            if (popOk_s)  rdPtr_r <= rdPtr_r + {{(AW-1){1'b0}}, 1'b1};
            count_r <= count_r + {{AW{1'b0}}, pushOk_s} - {{AW{1'b0}}, popOk_s};
        end
    end

    // Sample storage, deliberately not reset.
    always_ff @(posedge clk) begin
        if (pushOk_s && !flush) mem[wrPtr_r] <= wrData;
    end

endmodule

// File: rtl/sensor_reg_bank.sv
// ---------------------------------------------------------------------------
// sensor_reg_bank
// Register bank and sample FIFO downstream of the I2C slave.
//   clk, rst     : clock, synchronous active-high reset
//   bus          : register access bus (slave modport)
//   sample_valid : sensor sample strobe; sample_data : sensor sample
//   sample_en    : CTRL.EN, enables the sensor front end
//   irq          : registered active-high interrupt
// Optional feature macro: SENSOR_IRQ_EN (CTRL[3:2] interrupt enables and
// irq generation). Without it CTRL[3:2] read 0 and irq is tied low.
// ---------------------------------------------------------------------------
module sensor_reg_bank
    import sensor_reg_pkg::*;
#(
    parameter int         FIFO_DEPTH = 16,
    parameter int         FIFO_AW    = 4,
    parameter logic [7:0] DEVICE_ID  = DEVICE_ID_DEFAULT
) (
    input  logic               clk,
    input  logic               rst,
    sensor_reg_bank_if.slave   bus,
    input  logic               sample_valid,
    input  logic [7:0]         sample_data,
    output logic               sample_en,
    output logic               irq
);

    logic             ctrlEn_r;
    logic [7:0]       watermark_r;
    logic             ovf_r;
    logic             udf_r;
    logic [FIFO_AW:0] count_s;
    logic [7:0]       countExt_s;
    logic [7:0]       head_s;
    logic             empty_s;
    logic             full_s;
    logic             wrCtrl_s;
    logic             wrStatus_s;
    logic             flush_s;
    logic             pushReq_s;
    logic             popReq_s;
    logic             popOk_s;
    logic             ovfSet_s;
    logic             udfSet_s;
    logic             wm_s;
    logic [7:0]       ctrlRead_s;
    logic [7:0]       statusRead_s;

    assign wrCtrl_s   = bus.write_en & (bus.reg_addr == ADDR_CTRL);
    assign wrStatus_s = bus.write_en & (bus.reg_addr == ADDR_STATUS);
    assign flush_s    = wrCtrl_s & bus.wr_data[CTRL_FLUSH];
    assign pushReq_s  = sample_valid & ctrlEn_r;
    assign popReq_s   = bus.fifo_rd_en & (bus.reg_addr == ADDR_FIFO_DATA);
    assign popOk_s    = popReq_s & ~empty_s;
    // Overflow only when the sample is really dropped (no pop frees a slot).
    assign ovfSet_s   = pushReq_s & full_s & ~popOk_s;
    assign udfSet_s   = popReq_s & empty_s;
    assign countExt_s = 8'(count_s);
    // Watermarks above the depth can never be reached by count, so WM stays low.
    assign wm_s       = (watermark_r != 8'h00) & (countExt_s >= watermark_r);
    assign sample_en  = ctrlEn_r;

    sensor_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wrEn     (pushReq_s),
        .wrData   (sample_data),
        .rdEn     (popReq_s),
        .flush    (flush_s),
        .headData (head_s),
        .count    (count_s),
        .empty    (empty_s),
        .full     (full_s)
    );

`ifdef SENSOR_IRQ_EN
    logic ctrlWmIen_r;
    logic ctrlOvfIen_r;
    logic irq_r;

    // Interrupt enable bits of CTRL.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrlWmIen_r  <= 1'b0;
            ctrlOvfIen_r <= 1'b0;
        end else if (wrCtrl_s) begin
            ctrlWmIen_r  <= bus.wr_data[CTRL_WM_IEN];
            ctrlOvfIen_r <= bus.wr_data[CTRL_OVF_IEN];
        end
    end

    // Interrupt follows the status flags one cycle later.
    always_ff @(posedge clk) begin
        if (rst) irq_r <= 1'b0;
        else     irq_r <= (wm_s & ctrlWmIen_r) | (ovf_r & ctrlOvfIen_r);
    end

    assign irq = irq_r;
`else
    assign irq = 1'b0;
`endif

    // CTRL.EN and WATERMARK registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            ctrlEn_r    <= 1'b0;
            watermark_r <= 8'h00;
        end else begin
            if (wrCtrl_s) ctrlEn_r <= bus.wr_data[CTRL_EN];
            if (bus.write_en && (bus.reg_addr == ADDR_WATERMARK)) watermark_r <= bus.wr_data;
        end
    end

    // Sticky OVF/UDF; a new set event beats a same-cycle W1C.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_r <= 1'b0;
            udf_r <= 1'b0;
        end else begin
            if (ovfSet_s)                                 ovf_r <= 1'b1;
            else if (wrStatus_s && bus.wr_data[STAT_OVF]) ovf_r <= 1'b0;
            if (udfSet_s)                                 udf_r <= 1'b1;
            else if (wrStatus_s && bus.wr_data[STAT_UDF]) udf_r <= 1'b0;
        end
    end

    // CTRL and STATUS read images; FLUSH and reserved bits read 0.
    always_comb begin
        ctrlRead_s               = 8'h00;
        ctrlRead_s[CTRL_EN]      = ctrlEn_r;
`ifdef SENSOR_IRQ_EN
        ctrlRead_s[CTRL_WM_IEN]  = ctrlWmIen_r;
        ctrlRead_s[CTRL_OVF_IEN] = ctrlOvfIen_r;
`else
        ctrlRead_s[CTRL_WM_IEN]  = 1'b0;
        ctrlRead_s[CTRL_OVF_IEN] = 1'b0;
`endif
        statusRead_s             = 8'h00;
        statusRead_s[STAT_EMPTY] = empty_s;
        statusRead_s[STAT_FULL]  = full_s;
        statusRead_s[STAT_OVF]   = ovf_r;
        statusRead_s[STAT_UDF]   = udf_r;
        statusRead_s[STAT_WM]    = wm_s;
    end

    // Combinational read mux; unmapped addresses read zero.
    always_comb begin
        bus.rd_data = 8'h00;
        case (bus.reg_addr)
            ADDR_WHO_AM_I:  bus.rd_data = DEVICE_ID;
            ADDR_CTRL:      bus.rd_data = ctrlRead_s;
            ADDR_STATUS:    bus.rd_data = statusRead_s;
            ADDR_FIFO_CNT:  bus.rd_data = countExt_s;
            ADDR_FIFO_DATA: bus.rd_data = empty_s ? 8'h00 : head_s;
            ADDR_WATERMARK: bus.rd_data = watermark_r;
            default:        bus.rd_data = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_sensor_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_sensor_reg_bank
// Self-checking bench for sensor_reg_bank: table-driven register/FIFO
// vectors plus hand-written sequences for full-FIFO and interrupt timing.
// ---------------------------------------------------------------------------
module tb_sensor_reg_bank;

    logic       clk = 1'b0;
    logic       rst;
    logic       sample_valid;
    logic [7:0] sample_data;
    logic       sample_en;
    logic       irq;

    int checks   = 0;
    int failures = 0;

    sensor_reg_bank_if bus ();

    sensor_reg_bank #(
        .FIFO_DEPTH (16),
        .FIFO_AW    (4),
        .DEVICE_ID  (8'hA5)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .sample_en    (sample_en),
        .irq          (irq)
    );

    always #5 clk = ~clk;

    typedef enum int {OP_RD, OP_WR, OP_PUSH, OP_POP} opT;
    typedef struct {
        opT         op;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] exp;
    } vecT;

    vecT vecs[$];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %02h expected %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wrReg(input logic [7:0] a, input logic [7:0] d);
        bus.reg_addr = a;
        bus.wr_data  = d;
        bus.write_en = 1'b1;
        tick();
        bus.write_en = 1'b0;
    endtask

    task automatic rdChk(input string name, input logic [7:0] a, input logic [7:0] exp);
        bus.reg_addr = a;
        #1;
        check(name, bus.rd_data, exp);
    endtask

    task automatic pushS(input logic [7:0] d);
        sample_valid = 1'b1;
        sample_data  = d;
        tick();
        sample_valid = 1'b0;
    endtask

    // Pop through FIFO_DATA, checking the show-ahead head before the pop edge.
    task automatic popChk(input string name, input logic [7:0] exp);
        bus.reg_addr   = 8'h04;
        bus.fifo_rd_en = 1'b1;
        #1;
        check(name, bus.rd_data, exp);
        tick();
        bus.fifo_rd_en = 1'b0;
    endtask

    function automatic void addV(opT op, logic [7:0] a, logic [7:0] d, logic [7:0] e);
        vecT v;
        v.op = op; v.addr = a; v.data = d; v.exp = e;
        vecs.push_back(v);
    endfunction

    task automatic runVecs(input string tag);
        for (int i = 0; i < vecs.size(); i++) begin
            case (vecs[i].op)
                OP_RD:   rdChk($sformatf("%s_rd%0d", tag, i), vecs[i].addr, vecs[i].exp);
                OP_WR:   wrReg(vecs[i].addr, vecs[i].data);
                OP_PUSH: pushS(vecs[i].data);
                OP_POP:  popChk($sformatf("%s_pop%0d", tag, i), vecs[i].exp);
                default: ;
            endcase
        end
        vecs.delete();
    endtask

    initial begin
        rst            = 1'b1;
        sample_valid   = 1'b0;
        sample_data    = 8'h00;
        bus.reg_addr   = 8'h00;
        bus.wr_data    = 8'h00;
        bus.write_en   = 1'b0;
        bus.fifo_rd_en = 1'b0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Reset state
        check("rst_irq", {7'b0, irq}, 8'h00);
        check("rst_sample_en", {7'b0, sample_en}, 8'h00);
        addV(OP_RD, 8'h00, 8'h00, 8'hA5);
        addV(OP_RD, 8'h01, 8'h00, 8'h00);
        addV(OP_RD, 8'h02, 8'h00, 8'h01);
        addV(OP_RD, 8'h03, 8'h00, 8'h00);
        addV(OP_RD, 8'h04, 8'h00, 8'h00);
        addV(OP_RD, 8'h05, 8'h00, 8'h00);
        addV(OP_RD, 8'h77, 8'h00, 8'h00);
        // Basic push/pop
        addV(OP_WR, 8'h01, 8'h01, 8'h00);
        addV(OP_RD, 8'h01, 8'h00, 8'h01);
        addV(OP_PUSH, 8'h00, 8'h11, 8'h00);
        addV(OP_PUSH, 8'h00, 8'h22, 8'h00);
        addV(OP_PUSH, 8'h00, 8'h33, 8'h00);
        addV(OP_RD, 8'h03, 8'h00, 8'h03);
        addV(OP_RD, 8'h02, 8'h00, 8'h00);
        addV(OP_POP, 8'h04, 8'h00, 8'h11);
        addV(OP_POP, 8'h04, 8'h00, 8'h22);
        addV(OP_POP, 8'h04, 8'h00, 8'h33);
        addV(OP_RD, 8'h02, 8'h00, 8'h01);
        addV(OP_RD, 8'h03, 8'h00, 8'h00);
        runVecs("basic");
        check("en_sample_en", {7'b0, sample_en}, 8'h01);

        // Overflow: 17 pushes into a 16-deep FIFO
        for (int i = 0; i < 17; i++) pushS(8'h40 + 8'(i));
        rdChk("ovf_cnt", 8'h03, 8'h10);
        rdChk("ovf_status", 8'h02, 8'h06);
        wrReg(8'h02, 8'h04);
        rdChk("ovf_w1c", 8'h02, 8'h02);

        // Full FIFO, push and pop in the same cycle
        bus.reg_addr   = 8'h04;
        bus.fifo_rd_en = 1'b1;
        sample_valid   = 1'b1;
        sample_data    = 8'h99;
        #1;
        check("fullpp_head_before", bus.rd_data, 8'h40);
        tick();
        bus.fifo_rd_en = 1'b0;
        sample_valid   = 1'b0;
        rdChk("fullpp_head_after", 8'h04, 8'h41);
        rdChk("fullpp_cnt", 8'h03, 8'h10);
        rdChk("fullpp_status", 8'h02, 8'h02);

        // Drain: 0x41..0x4F then 0x99; the dropped 0x50 never appears
        for (int i = 1; i < 16; i++) popChk($sformatf("drain%0d", i), 8'h40 + 8'(i));
        popChk("drain_last", 8'h99);
        rdChk("drain_status", 8'h02, 8'h01);

        // Underflow, flush, W1C, watermark
        addV(OP_POP, 8'h04, 8'h00, 8'h00);
        addV(OP_RD, 8'h02, 8'h00, 8'h09);
        addV(OP_RD, 8'h03, 8'h00, 8'h00);
        addV(OP_PUSH, 8'h00, 8'h01, 8'h00);
        addV(OP_PUSH, 8'h00, 8'h02, 8'h00);
        addV(OP_PUSH, 8'h00, 8'h03, 8'h00);
        addV(OP_PUSH, 8'h00, 8'h04, 8'h00);
        addV(OP_PUSH, 8'h00, 8'h05, 8'h00);
        addV(OP_RD, 8'h03, 8'h00, 8'h05);
        addV(OP_WR, 8'h01, 8'h03, 8'h00);
        addV(OP_RD, 8'h03, 8'h00, 8'h00);
        addV(OP_RD, 8'h01, 8'h00, 8'h01);
        addV(OP_RD, 8'h02, 8'h00, 8'h09);
        addV(OP_WR, 8'h02, 8'h08, 8'h00);
        addV(OP_RD, 8'h02, 8'h00, 8'h01);
        addV(OP_WR, 8'h00, 8'h5A, 8'h00);
        addV(OP_RD, 8'h00, 8'h00, 8'hA5);
        addV(OP_WR, 8'h05, 8'h02, 8'h00);
        addV(OP_PUSH, 8'h00, 8'h61, 8'h00);
        addV(OP_RD, 8'h02, 8'h00, 8'h00);
        addV(OP_PUSH, 8'h00, 8'h62, 8'h00);
        addV(OP_RD, 8'h02, 8'h00, 8'h10);
        addV(OP_RD, 8'h05, 8'h00, 8'h02);
        addV(OP_WR, 8'h05, 8'h20, 8'h00);
        addV(OP_RD, 8'h02, 8'h00, 8'h00);
        addV(OP_WR, 8'h01, 8'h03, 8'h00);
        addV(OP_RD, 8'h02, 8'h00, 8'h01);
        runVecs("misc");
        check("misc_irq_low", {7'b0, irq}, 8'h00);

        // Interrupt timing
        wrReg(8'h05, 8'h04);
        wrReg(8'h01, 8'h05);
`ifdef SENSOR_IRQ_EN
        rdChk("irq_ctrl", 8'h01, 8'h05);
`else
        rdChk("irq_ctrl", 8'h01, 8'h01);
`endif
        for (int i = 0; i < 3; i++) pushS(8'h70 + 8'(i));
        tick();
        check("irq_cnt3", {7'b0, irq}, 8'h00);
        pushS(8'h73);
        check("irq_cnt4_edge", {7'b0, irq}, 8'h00);
        tick();
`ifdef SENSOR_IRQ_EN
        check("irq_wm_set", {7'b0, irq}, 8'h01);
`else
        check("irq_wm_set", {7'b0, irq}, 8'h00);
`endif
        popChk("irq_pop", 8'h70);
`ifdef SENSOR_IRQ_EN
        check("irq_pop_edge", {7'b0, irq}, 8'h01);
`else
        check("irq_pop_edge", {7'b0, irq}, 8'h00);
`endif
        tick();
        check("irq_wm_clr", {7'b0, irq}, 8'h00);
        rdChk("irq_cnt", 8'h03, 8'h03);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
